// File: rtl/dram_table_init.sv
// DRAM table initialiser: fills up to NUM_REGIONS regions with a per-region word pattern,
// optionally reads them back and compares, then releases the DRAM and flags done.
module dram_table_init #(
    parameter int unsigned DRAM_IO_WIDTH   = 256,
    parameter int unsigned DRAM_ADDR_WIDTH = 29,
    parameter int unsigned DRAM_MASK_WIDTH = 32,
    parameter int unsigned NUM_REGIONS     = 4,
    parameter int unsigned LEN_WIDTH       = 26
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 phy_init_done,
    input  logic [NUM_REGIONS*DRAM_ADDR_WIDTH-1:0] cfg_base,
    input  logic [NUM_REGIONS*LEN_WIDTH-1:0]     cfg_len,
    input  logic [NUM_REGIONS*2-1:0]             cfg_mode,
    input  logic [NUM_REGIONS*32-1:0]            cfg_seed,
    input  logic [NUM_REGIONS*32-1:0]            cfg_step,
    input  logic [NUM_REGIONS-1:0]               cfg_verify,
    output logic                                 dram_request_o,
    input  logic                                 dram_permit_i,
    output logic                                 release_dram_o,
    output logic                                 dram_en_o,
    output logic                                 dram_rd_wr_o,
    output logic [DRAM_ADDR_WIDTH-1:0]           addr_to_dram_o,
    input  logic                                 dram_ready_i,
    output logic [DRAM_IO_WIDTH-1:0]             data_to_dram_o,
    output logic [DRAM_MASK_WIDTH-1:0]           dram_data_mask_o,
    output logic                                 data_to_dram_en,
    output logic                                 data_to_dram_end,
    input  logic                                 data_to_dram_ready,
    input  logic                                 rd_data_valid_i,
    input  logic [DRAM_IO_WIDTH-1:0]             data_from_dram_i,
    output logic                                 init_dram_done,
    output logic                                 verify_error_o,
    output logic [15:0]                          err_count_o,
    output logic [3:0]                           err_region_o,
    output logic [DRAM_ADDR_WIDTH-1:0]           err_addr_o
);

    localparam int unsigned LANES = DRAM_IO_WIDTH / 32;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_SEL_W, S_WB0, S_WB1, S_WC,
        S_SEL_R, S_RC, S_RB0, S_RB1, S_REL, S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [4:0]                 region_q, region_d;
    logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                acc_q, acc_d;
    logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       request_q, request_d;
    logic                       release_q, release_d;
    logic                       cmd_en_q, cmd_en_d;
    logic                       rd_wr_q, rd_wr_d;
    logic [DRAM_IO_WIDTH-1:0]   wdata_q, wdata_d;
    logic                       wen_q, wen_d;
    logic                       wend_q, wend_d;
    logic                       done_q, done_d;
    logic                       verr_q, verr_d;
    logic [15:0]                err_cnt_q, err_cnt_d;
    logic [3:0]                 err_region_q, err_region_d;
    logic [DRAM_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic                       last_region, skip_w, cmd_last, check_beat, beat_mismatch;
    logic [3:0]                 sel;
    logic [DRAM_ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]       r_len, cnt_inc;
    logic [1:0]                 r_mode;
    logic [31:0]                r_seed, r_step, acc_inc;
    logic                       r_verify;
    logic [DRAM_IO_WIDTH-1:0]   beat_cur, beat_next, beat_seed;

    function automatic logic [DRAM_IO_WIDTH-1:0] make_beat(input logic [31:0] acc,
                                                           input logic [1:0]  mode,
                                                           input logic [31:0] seed,
                                                           input logic [31:0] step);
        logic [DRAM_IO_WIDTH-1:0] b;
        b = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            case (mode)
                2'b01:   b[k*32 +: 32] = seed;
                2'b10:   b[k*32 +: 32] = acc + 32'(k) * step;
                default: b[k*32 +: 32] = '0;
            endcase
        end
        return b;
    endfunction

    // region_q reaches NUM_REGIONS as the end marker; keep the slice index in range then
    assign last_region = (region_q == 5'(NUM_REGIONS));
    assign sel         = last_region ? 4'd0 : region_q[3:0];
    assign r_base      = cfg_base[sel*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
    assign r_len       = cfg_len[sel*LEN_WIDTH +: LEN_WIDTH];
    assign r_mode      = cfg_mode[sel*2 +: 2];
    assign r_seed      = cfg_seed[sel*32 +: 32];
    assign r_step      = cfg_step[sel*32 +: 32];
    assign r_verify    = cfg_verify[sel];
    assign skip_w      = (r_len == '0) || (r_mode == 2'b11);

    assign acc_inc     = acc_q + 32'(LANES) * r_step;
    assign cnt_inc     = cnt_q + 1'b1;
    assign cmd_last    = (cnt_inc == r_len);
    assign beat_cur    = make_beat(acc_q, r_mode, r_seed, r_step);
    assign beat_next   = make_beat(acc_inc, r_mode, r_seed, r_step);
    assign beat_seed   = make_beat(r_seed, r_mode, r_seed, r_step);

    assign check_beat    = ((state_q == S_RB0) || (state_q == S_RB1)) && rd_data_valid_i;
    assign beat_mismatch = (data_from_dram_i != beat_cur);

    always_comb begin
        state_d      = state_q;
        region_d     = region_q;
        addr_d       = addr_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        request_d    = request_q;
        release_d    = release_q;
        cmd_en_d     = cmd_en_q;
        rd_wr_d      = rd_wr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        wend_d       = wend_q;
        done_d       = done_q;
        verr_d       = verr_q;
        err_cnt_d    = err_cnt_q;
        err_region_d = err_region_q;
        err_addr_d   = err_addr_q;

        case (state_q)
            S_IDLE: if (phy_init_done) begin
                request_d = 1'b1;
                state_d   = S_REQ;
            end
            S_REQ: if (dram_permit_i) begin
                request_d = 1'b0;
                region_d  = '0;
                state_d   = S_SEL_W;
            end
            S_SEL_W: begin
                if (last_region) begin
                    region_d = '0;
                    state_d  = S_SEL_R;
                end else if (skip_w) begin
                    region_d = region_q + 5'd1;
                end else begin
                    addr_d  = r_base;
                    acc_d   = r_seed;
                    cnt_d   = '0;
                    wdata_d = beat_seed;
                    wen_d   = 1'b1;
                    wend_d  = 1'b0;
                    state_d = S_WB0;
                end
            end
            S_WB0: if (data_to_dram_ready) begin
                acc_d   = acc_inc;
                wdata_d = beat_next;
                wend_d  = 1'b1;
                state_d = S_WB1;
            end
            S_WB1: if (data_to_dram_ready) begin
                acc_d    = acc_inc;
                wen_d    = 1'b0;
                wend_d   = 1'b0;
                cmd_en_d = 1'b1;
                rd_wr_d  = 1'b0;
                state_d  = S_WC;
            end
            S_WC: if (dram_ready_i) begin
                cmd_en_d = 1'b0;
                cnt_d    = cnt_inc;
                addr_d   = addr_q + DRAM_ADDR_WIDTH'(8);
                if (cmd_last) begin
                    region_d = region_q + 5'd1;
                    state_d  = S_SEL_W;
                end else begin
                    wdata_d = beat_cur;
                    wen_d   = 1'b1;
                    state_d = S_WB0;
                end
            end
            S_SEL_R: begin
                if (last_region) begin
                    release_d = 1'b1;
                    state_d   = S_REL;
                end else if (skip_w || !r_verify) begin
                    region_d = region_q + 5'd1;
                end else begin
                    addr_d   = r_base;
                    acc_d    = r_seed;
                    cnt_d    = '0;
                    cmd_en_d = 1'b1;
                    rd_wr_d  = 1'b1;
                    state_d  = S_RC;
                end
            end
            S_RC: if (dram_ready_i) begin
                cmd_en_d = 1'b0;
                state_d  = S_RB0;
            end
            S_RB0: if (rd_data_valid_i) begin
                acc_d   = acc_inc;
                state_d = S_RB1;
            end
            S_RB1: if (rd_data_valid_i) begin
                acc_d  = acc_inc;
                cnt_d  = cnt_inc;
                addr_d = addr_q + DRAM_ADDR_WIDTH'(8);
                if (cmd_last) begin
                    region_d = region_q + 5'd1;
                    state_d  = S_SEL_R;
                end else begin
                    cmd_en_d = 1'b1;
                    state_d  = S_RC;
                end
            end
            S_REL: begin
                release_d = 1'b0;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        if (check_beat && beat_mismatch) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (!verr_q) begin
                verr_d       = 1'b1;
                err_region_d = region_q[3:0];
                err_addr_d   = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            region_q     <= '0;
            addr_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            request_q    <= 1'b0;
            release_q    <= 1'b0;
            cmd_en_q     <= 1'b0;
            rd_wr_q      <= 1'b0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            wend_q       <= 1'b0;
            done_q       <= 1'b0;
            verr_q       <= 1'b0;
            err_cnt_q    <= '0;
            err_region_q <= '0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            region_q     <= region_d;
            addr_q       <= addr_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            request_q    <= request_d;
            release_q    <= release_d;
            cmd_en_q     <= cmd_en_d;
            rd_wr_q      <= rd_wr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            wend_q       <= wend_d;
            done_q       <= done_d;
            verr_q       <= verr_d;
            err_cnt_q    <= err_cnt_d;
            err_region_q <= err_region_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign dram_request_o   = request_q;
    assign release_dram_o   = release_q;
    assign dram_en_o        = cmd_en_q;
    assign dram_rd_wr_o     = rd_wr_q;
    assign addr_to_dram_o   = addr_q;
    assign data_to_dram_o   = wdata_q;
    assign dram_data_mask_o = '0;
    assign data_to_dram_en  = wen_q;
    assign data_to_dram_end = wend_q;
    assign init_dram_done   = done_q;
    assign verify_error_o   = verr_q;
    assign err_count_o      = err_cnt_q;
    assign err_region_o     = err_region_q;
    assign err_addr_o       = err_addr_q;

endmodule

// File: tb/tb_dram_table_init.sv
// Bench for dram_table_init: DRAM/arbiter responder with a scoreboard of expected
// write beats, commands and release pulses, plus directed region configurations.
module tb_dram_table_init;

    localparam int unsigned IOW = 256;
    localparam int unsigned AW  = 29;
    localparam int unsigned NR  = 4;
    localparam int unsigned LW  = 26;

    logic             clk = 1'b0;
    logic             reset;
    logic             phy_init_done;
    logic [NR*AW-1:0] cfg_base;
    logic [NR*LW-1:0] cfg_len;
    logic [NR*2-1:0]  cfg_mode;
    logic [NR*32-1:0] cfg_seed;
    logic [NR*32-1:0] cfg_step;
    logic [NR-1:0]    cfg_verify;
    logic             dram_request_o, dram_permit_i, release_dram_o;
    logic             dram_en_o, dram_rd_wr_o, dram_ready_i;
    logic [AW-1:0]    addr_to_dram_o;
    logic [IOW-1:0]   data_to_dram_o, data_from_dram_i;
    logic [31:0]      dram_data_mask_o;
    logic             data_to_dram_en, data_to_dram_end, data_to_dram_ready;
    logic             rd_data_valid_i, init_dram_done, verify_error_o;
    logic [15:0]      err_count_o;
    logic [3:0]       err_region_o;
    logic [AW-1:0]    err_addr_o;

    always #5 clk = ~clk;

    dram_table_init #(
        .DRAM_IO_WIDTH(IOW), .DRAM_ADDR_WIDTH(AW), .DRAM_MASK_WIDTH(32),
        .NUM_REGIONS(NR), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset), .phy_init_done(phy_init_done),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
        .cfg_seed(cfg_seed), .cfg_step(cfg_step), .cfg_verify(cfg_verify),
        .dram_request_o(dram_request_o), .dram_permit_i(dram_permit_i),
        .release_dram_o(release_dram_o), .dram_en_o(dram_en_o),
        .dram_rd_wr_o(dram_rd_wr_o), .addr_to_dram_o(addr_to_dram_o),
        .dram_ready_i(dram_ready_i), .data_to_dram_o(data_to_dram_o),
        .dram_data_mask_o(dram_data_mask_o), .data_to_dram_en(data_to_dram_en),
        .data_to_dram_end(data_to_dram_end), .data_to_dram_ready(data_to_dram_ready),
        .rd_data_valid_i(rd_data_valid_i), .data_from_dram_i(data_from_dram_i),
        .init_dram_done(init_dram_done), .verify_error_o(verify_error_o),
        .err_count_o(err_count_o), .err_region_o(err_region_o), .err_addr_o(err_addr_o)
    );

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
    } cmd_t;

    logic [IOW-1:0] exp_beat_q[$];
    cmd_t           exp_cmd_q[$];
    int             exp_rel;
    int             checks   = 0;
    int             failures = 0;

    logic [IOW-1:0] mem [logic [AW:0]];
    logic [IOW-1:0] rd_pend[$];
    logic [IOW-1:0] wbuf [2];
    int             stall_budget;
    logic           corrupt_en;
    logic [AW-1:0]  corrupt_addr;

    logic           p_wstall, p_cstall, p_end, p_rw;
    logic [IOW-1:0] p_data, eb, b0, b1;
    logic [AW-1:0]  p_addr;
    cmd_t           ec;
    bit             stall;

    task automatic check(input string name, input logic [IOW-1:0] act, input logic [IOW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Responder and monitor: arbiter grant, DRAM memory, stalls, scoreboard pops.
    always @(negedge clk) begin
        if (!reset) begin
            dram_permit_i      = 1'b0;
            dram_ready_i       = 1'b0;
            data_to_dram_ready = 1'b0;
            rd_data_valid_i    = 1'b0;
            p_wstall           = 1'b0;
            p_cstall           = 1'b0;
        end else begin
            if (p_wstall)
                check("wbeat_hold", {data_to_dram_en, data_to_dram_end, data_to_dram_o},
                      {1'b1, p_end, p_data});
            if (p_cstall)
                check("cmd_hold", {dram_en_o, dram_rd_wr_o, addr_to_dram_o}, {1'b1, p_rw, p_addr});

            dram_permit_i = dram_request_o;

            if (rd_pend.size() > 0) begin
                rd_data_valid_i  = 1'b1;
                data_from_dram_i = rd_pend.pop_front();
            end else begin
                rd_data_valid_i = 1'b0;
            end

            stall = 1'b0;
            if ((data_to_dram_en || dram_en_o) && stall_budget > 0 && $urandom_range(0, 1) == 1) begin
                stall = 1'b1;
                stall_budget--;
            end

            data_to_dram_ready = data_to_dram_en && !stall;
            p_wstall = data_to_dram_en && !data_to_dram_ready;
            p_data   = data_to_dram_o;
            p_end    = data_to_dram_end;
            if (data_to_dram_en && data_to_dram_ready) begin
                eb = (exp_beat_q.size() > 0) ? exp_beat_q.pop_front() : 'x;
                check("wbeat", data_to_dram_o, eb);
                wbuf[data_to_dram_end] = data_to_dram_o;
            end

            dram_ready_i = dram_en_o && !stall;
            p_cstall = dram_en_o && !dram_ready_i;
            p_addr   = addr_to_dram_o;
            p_rw     = dram_rd_wr_o;
            if (dram_en_o && dram_ready_i) begin
                ec = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 'x;
                check("cmd", {dram_rd_wr_o, addr_to_dram_o}, ec);
                if (!dram_rd_wr_o) begin
                    mem[{addr_to_dram_o, 1'b0}] = wbuf[0];
                    mem[{addr_to_dram_o, 1'b1}] = wbuf[1];
                end else begin
                    b0 = mem.exists({addr_to_dram_o, 1'b0}) ? mem[{addr_to_dram_o, 1'b0}] : '0;
                    b1 = mem.exists({addr_to_dram_o, 1'b1}) ? mem[{addr_to_dram_o, 1'b1}] : '0;
                    if (corrupt_en && addr_to_dram_o == corrupt_addr) b1[0] = ~b1[0];
                    rd_pend.push_back(b0);
                    rd_pend.push_back(b1);
                end
            end

            if (release_dram_o) begin
                check("release_pulse", exp_rel, 1);
                exp_rel = 0;
            end
        end
    end

    function automatic logic [IOW-1:0] fill(input logic [31:0] w);
        return {8{w}};
    endfunction

    // Closed form: lane k of beat n is seed + (8n + k) * step.
    function automatic logic [IOW-1:0] inc_beat(input logic [31:0] seed, input logic [31:0] step,
                                                input int n);
        logic [IOW-1:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = seed + 32'(8 * n + k) * step;
        return b;
    endfunction

    task automatic exp_write(input logic [AW-1:0] addr, input logic [IOW-1:0] w0, input logic [IOW-1:0] w1);
        exp_beat_q.push_back(w0);
        exp_beat_q.push_back(w1);
        exp_cmd_q.push_back('{rd: 1'b0, addr: addr});
    endtask

    task automatic exp_read(input logic [AW-1:0] addr);
        exp_cmd_q.push_back('{rd: 1'b1, addr: addr});
    endtask

    task automatic set_region(input int r, input logic [AW-1:0] base, input logic [LW-1:0] len,
                              input logic [1:0] mode, input logic [31:0] seed,
                              input logic [31:0] step, input logic ver);
        cfg_base[r*AW +: AW] = base;
        cfg_len[r*LW +: LW]  = len;
        cfg_mode[r*2 +: 2]   = mode;
        cfg_seed[r*32 +: 32] = seed;
        cfg_step[r*32 +: 32] = step;
        cfg_verify[r]        = ver;
    endtask

    task automatic flush();
        exp_beat_q.delete();
        exp_cmd_q.delete();
        rd_pend.delete();
        mem.delete();
        exp_rel      = 0;
        stall_budget = 0;
        corrupt_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        flush();
        cfg_base = '0; cfg_len = '0; cfg_mode = '0; cfg_seed = '0; cfg_step = '0; cfg_verify = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic start();
        exp_rel = 1;
        @(negedge clk);
        phy_init_done = 1'b1;
        @(negedge clk);
        phy_init_done = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!init_dram_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, init_dram_done, 1);
        repeat (3) @(negedge clk);
        check({name, "_beats_left"}, exp_beat_q.size(), 0);
        check({name, "_cmds_left"}, exp_cmd_q.size(), 0);
        check({name, "_release_left"}, exp_rel, 0);
        check({name, "_done_sticky"}, init_dram_done, 1);
    endtask

    task automatic setup_t1();
        set_region(0, 29'h100, 2, 2'b01, 32'h7FFF_FFFF, 32'h0, 1'b0);
        exp_write(29'h100, fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF));
        exp_write(29'h108, fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF));
    endtask

    initial begin
        int n;
        reset = 1'b0; phy_init_done = 1'b0;
        dram_permit_i = 1'b0; dram_ready_i = 1'b0; data_to_dram_ready = 1'b0;
        rd_data_valid_i = 1'b0; data_from_dram_i = '0;
        flush();
        do_reset();

        check("rst_data", {data_to_dram_o}, '0);
        check("rst_ctrl", {dram_request_o, release_dram_o, dram_en_o, dram_rd_wr_o, addr_to_dram_o,
                           dram_data_mask_o, data_to_dram_en, data_to_dram_end, init_dram_done,
                           verify_error_o, err_count_o, err_region_o, err_addr_o}, '0);

        // constant seed, single region
        setup_t1();
        start();
        wait_done("t1");
        check("t1_errs", {verify_error_o, err_count_o}, '0);

        // incrementing pattern
        do_reset();
        set_region(0, 29'h0, 1, 2'b10, 32'h0, 32'h800, 1'b0);
        exp_write(29'h0, inc_beat(32'h0, 32'h800, 0), inc_beat(32'h0, 32'h800, 1));
        start();
        wait_done("t2");

        // skipped regions, zero mode ignores seed, address wrap in region 3
        do_reset();
        set_region(0, 29'h10, 0, 2'b01, 32'h1111_1111, 32'h0, 1'b0);
        set_region(1, 29'h40, 1, 2'b00, 32'h1234_5678, 32'h1, 1'b0);
        set_region(2, 29'h80, 3, 2'b11, 32'h2222_2222, 32'h0, 1'b0);
        set_region(3, 29'h1FFF_FFF8, 2, 2'b01, 32'hA5A5_A5A5, 32'h0, 1'b0);
        exp_write(29'h40, '0, '0);
        exp_write(29'h1FFF_FFF8, fill(32'hA5A5_A5A5), fill(32'hA5A5_A5A5));
        exp_write(29'h0, fill(32'hA5A5_A5A5), fill(32'hA5A5_A5A5));
        start();
        wait_done("t3");

        // ready stalls
        do_reset();
        set_region(0, 29'h300, 4, 2'b10, 32'h10, 32'h3, 1'b0);
        for (int c = 0; c < 4; c++)
            exp_write(29'h300 + 29'(8 * c), inc_beat(32'h10, 32'h3, 2 * c), inc_beat(32'h10, 32'h3, 2 * c + 1));
        stall_budget = 5;
        start();
        wait_done("t4");

        // verify with one corrupted beat
        do_reset();
        set_region(0, 29'h100, 1, 2'b01, 32'h5, 32'h0, 1'b1);
        set_region(1, 29'h200, 4, 2'b10, 32'h1, 32'h1, 1'b1);
        exp_write(29'h100, fill(32'h5), fill(32'h5));
        for (int c = 0; c < 4; c++)
            exp_write(29'h200 + 29'(8 * c), inc_beat(32'h1, 32'h1, 2 * c), inc_beat(32'h1, 32'h1, 2 * c + 1));
        exp_read(29'h100);
        for (int c = 0; c < 4; c++) exp_read(29'h200 + 29'(8 * c));
        corrupt_en   = 1'b1;
        corrupt_addr = 29'h218;
        start();
        wait_done("t5");
        check("t5_verr", verify_error_o, 1);
        check("t5_cnt", err_count_o, 1);
        check("t5_region", err_region_o, 1);
        check("t5_addr", err_addr_o, 29'h218);

        // reset during the second write beat, then rerun
        do_reset();
        setup_t1();
        start();
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!data_to_dram_end && n < 100);
        check("t6_reach_wb1", data_to_dram_end, 1);
        reset = 1'b0;
        #1;
        check("t6_abort_data", data_to_dram_o, '0);
        check("t6_abort_ctrl", {dram_request_o, release_dram_o, dram_en_o, dram_rd_wr_o, addr_to_dram_o,
                                data_to_dram_en, data_to_dram_end, init_dram_done}, '0);
        flush();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        setup_t1();
        start();
        wait_done("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
